// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Holds the funct3 op encodings, the M-extension funct7 value, the FSM state
// type and small helpers that classify operand signedness per op.
package ex_muldiv_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Operand A is interpreted as signed for these ops.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand B is interpreted as signed for these ops.
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit.
// master: EX stage / pipeline control (drives op request and flush).
// slave : the muldiv unit (returns busy, done pulse, result, stall request).
//   start     - M-op present in EX
//   funct3    - op select (MUL..REMU)
//   rs1_val   - operand A after forwarding
//   rs2_val   - operand B after forwarding
//   flush     - kill of the EX instruction
//   busy      - unit not idle
//   done      - one-cycle result-valid pulse
//   result    - final result, held until the next accepted start
//   stall_req - hold PC, IF/ID, ID/EX
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall_req;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  busy, done, result, stall_req
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output busy, done, result, stall_req
  );
endinterface

// File: rtl/ex_muldiv_unit_iter_core.sv
// Unsigned iterative datapath for the muldiv unit (muldiv_iter_core).
// Multiply: radix-2 shift-add, {hi,lo} holds the running product with the
// multiplier shifting out of lo. Divide: restoring, hi is the partial
// remainder and lo shifts the dividend out while quotient bits shift in.
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_load           - latch magnitudes, clear accumulator, load counter
//   i_en             - perform one iteration
//   i_is_div         - latched at load: 1 divide, 0 multiply
//   i_a_mag, i_b_mag - unsigned operand magnitudes
//   o_last           - the iteration performed this cycle is the final one
//   o_hi, o_lo       - hi/lo state after this cycle's iteration
module ex_muldiv_unit_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_en,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a_mag,
  input  logic [XLEN-1:0] i_b_mag,
  output logic            o_last,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_is_div;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift  = {r_hi, r_lo[XLEN-1]};
    // Only used when w_shift >= r_b, where the true difference fits in XLEN bits.
    w_diff   = w_shift[XLEN-1:0] - r_b;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      if (w_shift >= {1'b0, r_b}) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Add-then-shift: the carry out of the add becomes the new hi MSB.
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= CntW'(XLEN);
      r_hi     <= '0;
      r_lo     <= i_a_mag;
      r_b      <= i_b_mag;
      r_is_div <= i_is_div;
    end else if (i_en) begin
      r_cnt    <= r_cnt - CntW'(1);
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign o_last = (r_cnt == CntW'(1));
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// Owns the IDLE/CALC/FIN FSM, sign pre/post-processing, the divide special
// cases (divisor zero, signed overflow) and the stall/done handshake.
// Normal ops finish XLEN+1 cycles after acceptance; special cases in 1.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - synchronous active-high reset
//   io_bus - ex_muldiv_unit_if slave: start/funct3/rs1_val/rs2_val/flush in,
//            busy/done/result/stall_req out
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ex_muldiv_unit_if.slave  io_bus
);
  import ex_muldiv_unit_pkg::*;

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_f3;
  logic            r_neg_p;  // product / quotient sign
  logic            r_neg_r;  // remainder sign

  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [2:0]        w_f3;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_accept;
  logic              w_core_load;
  logic              w_core_en;
  logic              w_core_last;
  logic [XLEN-1:0]   w_core_hi;
  logic [XLEN-1:0]   w_core_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Operand decode in the accept cycle.
  always_comb begin
    w_a        = io_bus.rs1_val;
    w_b        = io_bus.rs2_val;
    w_f3       = io_bus.funct3;
    w_a_neg    = op_a_signed(w_f3) & w_a[XLEN-1];
    w_b_neg    = op_b_signed(w_f3) & w_b[XLEN-1];
    w_a_mag    = w_a_neg ? -w_a : w_a;
    w_b_mag    = w_b_neg ? -w_b : w_b;
    w_div_zero = w_f3[2] & (w_b == '0);
    w_ovf      = ((w_f3 == F3_DIV) || (w_f3 == F3_REM)) &&
                 (w_a == SIGNED_MIN) && (w_b == '1);
    w_special  = w_div_zero | w_ovf;
    // funct3[1] selects the remainder flavour among the divide ops.
    if (w_div_zero) begin
      w_special_res = w_f3[1] ? w_a : '1;
    end else begin
      w_special_res = w_f3[1] ? '0 : SIGNED_MIN;
    end
    w_accept    = (r_state == S_IDLE) & io_bus.start & ~io_bus.flush;
    w_core_load = w_accept & ~w_special;
    w_core_en   = (r_state == S_CALC) & ~io_bus.flush;
  end

  // Sign post-processing of the core's final iteration.
  always_comb begin
    w_prod = {w_core_hi, w_core_lo};
    if (r_neg_p) begin
      w_prod = -w_prod;
    end
    w_quo = r_neg_p ? -w_core_lo : w_core_lo;
    w_rem = r_neg_r ? -w_core_hi : w_core_hi;
    w_final = '0;
    case (r_f3)
      F3_MUL:                       w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

  ex_muldiv_unit_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_core_load),
    .i_en     (w_core_en),
    .i_is_div (w_f3[2]),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_last   (w_core_last),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_f3     <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (io_bus.flush) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (io_bus.start) begin
              r_f3    <= w_f3;
              r_neg_p <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              if (w_special) begin
                r_result <= w_special_res;
                r_done   <= 1'b1;
                r_state  <= S_FIN;
              end else begin
                r_state  <= S_CALC;
              end
            end
          end
          S_CALC: begin
            if (w_core_last) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end
          end
          // A start seen here is the op just completed; the next one arrives in IDLE.
          S_FIN:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.done      = r_done;
  assign io_bus.result    = r_result;
  // Low in FIN so ID/EX advances exactly on the done cycle.
  assign io_bus.stall_req = ~i_rst & (w_accept | (r_state == S_CALC));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_done;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint            sa = longint'($signed(a));
    longint            sb = longint'($signed(b));
    longint            ub = longint'({32'b0, b});
    longint unsigned   ua = longint'({32'b0, a});
    longint unsigned   uu = longint'({32'b0, b});
    logic [63:0]       p;
    logic              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    int                ia = int'(a);
    int                ib = int'(b);
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * uu; return p[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Presents an op at cycle 0 and holds start (as a stalled ID/EX would) until done.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output logic [31:0] res, output int lat,
                       output int stalls);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b;
    lat = -1; stalls = 0; res = 32'hx;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.stall_req === 1'b1) stalls++;
      if (bus.done === 1'b1) begin
        lat = c; res = bus.result;
        break;
      end
      if (scramble) begin
        @(posedge clk); #1;
        bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.funct3 = 3'($urandom);
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.funct3 = F3_MUL;
    bus.rs1_val = 32'h1234; bus.rs2_val = 32'h5678; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    if (bus.result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", bus.result); end
    if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall_req); end
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    total += 3;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL post_rst_done got=%b exp=0", bus.done); end
    if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%b exp=0", bus.stall_req); end
  endtask

  task automatic test_mul_latency();
    logic [31:0] res;
    int lat, st;
    do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, res, lat, st);
    total += 3;
    if (res !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
    if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    if (st != 33) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=33", st); end
    go_idle();
    @(negedge clk);
    total += 2;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", bus.done); end
    if (bus.result !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul_result_hold got=%h exp=ffffffeb", bus.result);
    end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f3s [3] = '{F3_MULHU, F3_MULH, F3_MULHSU};
    logic [31:0] exps [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, st;
    for (int i = 0; i < 3; i++) begin
      do_op(f3s[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, st);
      total += 2;
      if (res !== exps[i]) begin
        bad++; $display("FAIL mulhigh_result f3=%0d got=%h exp=%h", f3s[i], res, exps[i]);
      end
      if (lat != 33) begin bad++; $display("FAIL mulhigh_latency f3=%0d got=%0d exp=33", f3s[i], lat); end
    end
    go_idle();
  endtask

  task automatic test_special();
    logic [2:0]  f3s [4] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] res;
    int lat, st;
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs[i], 1'b1, res, lat, st);
      total += 2;
      if (res !== exps[i]) begin
        bad++; $display("FAIL special_result idx=%0d got=%h exp=%h", i, res, exps[i]);
      end
      if (lat != 1) begin bad++; $display("FAIL special_latency idx=%0d got=%0d exp=1", i, lat); end
    end
    go_idle();
  endtask

  task automatic test_div();
    logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_DIVU};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] exps [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    logic [31:0] res;
    int lat, st;
    for (int i = 0; i < 3; i++) begin
      do_op(f3s[i], as[i], 32'd2, 1'b0, res, lat, st);
      total += 2;
      if (res !== exps[i]) begin
        bad++; $display("FAIL div_result idx=%0d got=%h exp=%h", i, res, exps[i]);
      end
      if (lat != 33) begin bad++; $display("FAIL div_latency idx=%0d got=%0d exp=33", i, lat); end
    end
    go_idle();
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat, st, d0;
    prev = bus.result;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.rs1_val = 32'd123; bus.rs2_val = 32'd456;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    d0 = n_done;
    @(negedge clk);
    total += 2;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.stall_req); end
    repeat (40) @(negedge clk);
    total += 2;
    if (n_done != d0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", n_done - d0); end
    if (bus.result !== prev) begin bad++; $display("FAIL flush_result got=%h exp=%h", bus.result, prev); end
    do_op(F3_DIVU, 32'd100, 32'd7, 1'b0, res, lat, st);
    total += 2;
    if (res !== 32'd14) begin bad++; $display("FAIL flush_divu_result got=%h exp=0000000e", res); end
    if (lat != 33) begin bad++; $display("FAIL flush_divu_latency got=%0d exp=33", lat); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int d0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = F3_DIV; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = n_done;
    @(negedge clk);
    total += 4;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
    if (bus.result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
    if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_req); end
    repeat (40) @(negedge clk);
    total += 1;
    if (n_done != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done - d0); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s [5] = '{F3_MULHU, F3_DIVU, F3_REM, F3_DIV, F3_MUL};
    logic [31:0] as  [5] = '{32'h0001_0000, 32'd1000, 32'hFFFF_FF9C, 32'd9, 32'h0000_FFFF};
    logic [31:0] bs  [5] = '{32'h0002_0000, 32'd10, 32'd7, 32'd0, 32'h0001_0001};
    logic [31:0] exps [5] = '{32'h2, 32'd100, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, st, d0;
    d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      do_op(f3s[i], as[i], bs[i], 1'b0, res, lat, st);
      total += 1;
      if (res !== exps[i]) begin
        bad++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, res, exps[i]);
      end
    end
    go_idle();
    repeat (5) @(negedge clk);
    total += 1;
    if (n_done - d0 != 5) begin bad++; $display("FAIL b2b_done_count got=%0d exp=5", n_done - d0); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp;
    int lat, st, elat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(f3, a, b);
      elat = ref_latency(f3, a, b);
      do_op(f3, a, b, 1'($urandom_range(0, 1)), res, lat, st);
      total += 2;
      if (res !== exp) begin
        bad++; $display("FAIL rand_result f3=%0d a=%h b=%h got=%h exp=%h", f3, a, b, res, exp);
      end
      if (lat != elat) begin
        bad++; $display("FAIL rand_latency f3=%0d a=%h b=%h got=%0d exp=%0d", f3, a, b, lat, elat);
      end
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    total = 0; bad = 0; n_done = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.flush = 1'b0;
    test_reset();
    test_mul_latency();
    test_mul_high();
    test_special();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
